// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared types and sizing helpers for the BRAM-backed FIFO controller.
package bram_fifo_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 36;
    localparam int unsigned ADDR_W_DEF = 9;

    // Output skid buffer occupancy; encoding doubles as the entry count.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // COUNT must hold the value DEPTH itself, hence one bit wider than the address.
    function automatic int unsigned cnt_w(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Push/pop handshakes plus both BRAM ports of the FIFO controller.
interface bram_fifo_ctrl_if
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned data_w = DATA_W_DEF,
    parameter int unsigned addr_w = ADDR_W_DEF
) ();

    localparam int unsigned CNT_W = cnt_w(addr_w);

    logic              FLUSH;
    logic              WR_VALID;
    logic              WR_READY;
    logic [data_w-1:0] WR_DATA;
    logic              RD_VALID;
    logic              RD_READY;
    logic [data_w-1:0] RD_DATA;
    logic [CNT_W-1:0]  COUNT;

    logic              BRAM_ENA;
    logic              BRAM_WEA;
    logic [addr_w-1:0] BRAM_ADDRA;
    logic [data_w-1:0] BRAM_DIA;
    logic              BRAM_ENB;
    logic              BRAM_WEB;
    logic              BRAM_SSRB;
    logic [addr_w-1:0] BRAM_ADDRB;
    logic [data_w-1:0] BRAM_DOB;

    // Controller side.
    modport slave (
        input  FLUSH, WR_VALID, WR_DATA, RD_READY, BRAM_DOB,
        output WR_READY, RD_VALID, RD_DATA, COUNT,
        output BRAM_ENA, BRAM_WEA, BRAM_ADDRA, BRAM_DIA,
        output BRAM_ENB, BRAM_WEB, BRAM_SSRB, BRAM_ADDRB
    );

    // Core plus BRAM side.
    modport master (
        output FLUSH, WR_VALID, WR_DATA, RD_READY, BRAM_DOB,
        input  WR_READY, RD_VALID, RD_DATA, COUNT,
        input  BRAM_ENA, BRAM_WEA, BRAM_ADDRA, BRAM_DIA,
        input  BRAM_ENB, BRAM_WEB, BRAM_SSRB, BRAM_ADDRB
    );

endinterface

// File: rtl/bram_fifo_skid.sv
// Two-entry output buffer absorbing the BRAM's registered read data.
module bram_fifo_skid
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned data_w = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_valid,
    input  logic [data_w-1:0] cap_data,
    input  logic              pop,
    input  logic              flush,
    output logic [1:0]        occ,
    output logic              head_valid,
    output logic [data_w-1:0] head_data
);

    skid_state_e       state_q, state_d;
    logic [data_w-1:0] head_q, head_d;
    logic [data_w-1:0] tail_q, tail_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // The issue logic upstream never lets a capture land on a full buffer.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (cap_valid) begin
                        head_d  = cap_data;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    case ({cap_valid, pop})
                        2'b10: begin
                            tail_d  = cap_data;
                            state_d = SKID_TWO;
                        end
                        2'b01: state_d = SKID_EMPTY;
                        2'b11: head_d = cap_data;
                        default: ;
                    endcase
                end
                SKID_TWO: begin
                    if (pop) begin
                        head_d = tail_q;
                        if (cap_valid) begin
                            tail_d = cap_data;
                        end else begin
                            state_d = SKID_ONE;
                        end
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    assign occ        = 2'(state_q);
    assign head_valid = (state_q != SKID_EMPTY);
    assign head_data  = head_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller driving both ports of an external dual-port BRAM,
// with a skid buffer hiding the one-cycle read latency.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned data_w = DATA_W_DEF,
    parameter int unsigned addr_w = ADDR_W_DEF
) (
    input logic             CLK,
    input logic             RST_N,
    bram_fifo_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = cnt_w(addr_w);
    localparam int unsigned DEPTH = depth(addr_w);

    logic [addr_w-1:0] wptr_q, wptr_d;
    logic [addr_w-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;

    logic              push_c;
    logic              pop_c;
    logic              issue_c;
    logic [1:0]        pend_c;
    logic [1:0]        skid_occ;
    logic              skid_valid;
    logic [data_w-1:0] skid_data;

    // Push is masked while in reset so port A stays quiet during an async clear.
    assign push_c  = bus.WR_VALID & bus.WR_READY & ~bus.FLUSH & RST_N;
    assign pop_c   = skid_valid & bus.RD_READY;
    assign pend_c  = skid_occ + {1'b0, inflight_q};
    assign issue_c = ~bus.FLUSH & (mem_cnt_q != '0)
                   & ((pend_c < 2'd2) | (pop_c & (pend_c == 2'd2)));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_cnt_q  <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_cnt_q  <= mem_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_cnt_d  = mem_cnt_q;
        count_d    = count_q;
        inflight_d = 1'b0;
        if (bus.FLUSH) begin
            wptr_d    = '0;
            rptr_d    = '0;
            mem_cnt_d = '0;
            count_d   = '0;
        end else begin
            if (push_c) begin
                wptr_d = wptr_q + addr_w'(1);
            end
            if (issue_c) begin
                rptr_d = rptr_q + addr_w'(1);
            end
            mem_cnt_d  = mem_cnt_q + CNT_W'(push_c) - CNT_W'(issue_c);
            count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            inflight_d = issue_c;
        end
    end

    bram_fifo_skid #(
        .data_w(data_w)
    ) u_skid (
        .clk       (CLK),
        .rst_n     (RST_N),
        .cap_valid (inflight_q),
        .cap_data  (bus.BRAM_DOB),
        .pop       (pop_c),
        .flush     (bus.FLUSH),
        .occ       (skid_occ),
        .head_valid(skid_valid),
        .head_data (skid_data)
    );

    assign bus.WR_READY   = (count_q < CNT_W'(DEPTH));
    assign bus.RD_VALID   = skid_valid;
    assign bus.RD_DATA    = skid_data;
    assign bus.COUNT      = count_q;

    assign bus.BRAM_ENA   = push_c;
    assign bus.BRAM_WEA   = push_c;
    assign bus.BRAM_ADDRA = wptr_q;
    assign bus.BRAM_DIA   = bus.WR_DATA;
    assign bus.BRAM_ENB   = issue_c;
    assign bus.BRAM_ADDRB = rptr_q;
    assign bus.BRAM_WEB   = 1'b0;
    assign bus.BRAM_SSRB  = 1'b0;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: 16-deep instance, behavioural BRAM, vector table plus scoreboarded sequences.
module tb_bram_fifo_ctrl;

    localparam int unsigned DW    = 36;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NV    = 14;

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic          fl;
        logic          e_wrdy;
        logic          e_rdv;
        logic [DW-1:0] e_rdd;
        logic [CW-1:0] e_cnt;
        logic          e_ena;
        logic          e_enb;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_vec = 0;
    int   n_err = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] mem[DEPTH];
    vec_t vt[NV];

    bram_fifo_ctrl_if #(.data_w(DW), .addr_w(AW)) bus ();

    bram_fifo_ctrl #(.data_w(DW), .addr_w(AW)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Dual-port BRAM with registered read port, old data on collision.
    always @(posedge CLK) begin
        if (bus.BRAM_ENA && bus.BRAM_WEA) mem[bus.BRAM_ADDRA] <= bus.BRAM_DIA;
        if (bus.BRAM_ENB) bus.BRAM_DOB <= mem[bus.BRAM_ADDRB];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wv, input logic [DW-1:0] wd, input logic rr,
                                input logic fl, input logic e_wrdy, input logic e_rdv,
                                input logic [DW-1:0] e_rdd, input logic [CW-1:0] e_cnt,
                                input logic e_ena, input logic e_enb);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rr = rr; v.fl = fl;
        v.e_wrdy = e_wrdy; v.e_rdv = e_rdv; v.e_rdd = e_rdd;
        v.e_cnt = e_cnt; v.e_ena = e_ena; v.e_enb = e_enb;
        return v;
    endfunction

    task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
        bus.WR_VALID = wv;
        bus.WR_DATA  = wd;
        bus.RD_READY = rr;
        bus.FLUSH    = fl;
    endtask

    // One clock cycle against the queue model; entered and left at posedge+1.
    task automatic cyc(input logic wv, input logic [DW-1:0] wd, input logic rr,
                       input logic fl, output logic popped);
        drive(wv, wd, rr, fl);
        @(negedge CLK);
        chk("count", 64'(bus.COUNT), 64'(sb.size()));
        chk("wr_ready", 64'(bus.WR_READY), 64'(sb.size() < DEPTH));
        if (bus.BRAM_ENA && bus.BRAM_ENB)
            chk("addr_collide", 64'(bus.BRAM_ADDRA == bus.BRAM_ADDRB), 64'(0));
        if (fl) begin
            chk("flush_ena", 64'(bus.BRAM_ENA), 64'(0));
            chk("flush_enb", 64'(bus.BRAM_ENB), 64'(0));
        end
        popped = bus.RD_VALID && rr && !fl;
        if (popped) begin
            chk("pop_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) chk("rd_data", 64'(bus.RD_DATA), 64'(sb.pop_front()));
        end
        if (wv && bus.WR_READY && !fl) sb.push_back(wd);
        if (fl) sb.delete();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int limit);
        int   n = 0;
        logic p;
        while (sb.size() != 0 && n < limit) begin
            cyc(1'b0, '0, 1'b1, 1'b0, p);
            n++;
        end
        chk("drain_done", 64'(sb.size()), 64'(0));
        chk("drain_rd_valid", 64'(bus.RD_VALID), 64'(0));
    endtask

    initial begin
        logic p;
        int   first;
        int   npop;
        int   bub;

        vt[0]  = mk(1'b1, 36'h1A5, 1'b1, 1'b0, 1'b1, 1'b0, 36'h0,   5'd0, 1'b1, 1'b0);
        vt[1]  = mk(1'b0, 36'h0,   1'b1, 1'b0, 1'b1, 1'b0, 36'h0,   5'd1, 1'b0, 1'b1);
        vt[2]  = mk(1'b0, 36'h0,   1'b1, 1'b0, 1'b1, 1'b0, 36'h0,   5'd1, 1'b0, 1'b0);
        vt[3]  = mk(1'b0, 36'h0,   1'b1, 1'b0, 1'b1, 1'b1, 36'h1A5, 5'd1, 1'b0, 1'b0);
        vt[4]  = mk(1'b0, 36'h0,   1'b1, 1'b0, 1'b1, 1'b0, 36'h0,   5'd0, 1'b0, 1'b0);
        vt[5]  = mk(1'b1, 36'h011, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0,   5'd0, 1'b1, 1'b0);
        vt[6]  = mk(1'b1, 36'h022, 1'b0, 1'b0, 1'b1, 1'b0, 36'h0,   5'd1, 1'b1, 1'b1);
        vt[7]  = mk(1'b0, 36'h0,   1'b0, 1'b0, 1'b1, 1'b0, 36'h0,   5'd2, 1'b0, 1'b1);
        vt[8]  = mk(1'b0, 36'h0,   1'b0, 1'b0, 1'b1, 1'b1, 36'h011, 5'd2, 1'b0, 1'b0);
        vt[9]  = mk(1'b0, 36'h0,   1'b1, 1'b0, 1'b1, 1'b1, 36'h011, 5'd2, 1'b0, 1'b0);
        vt[10] = mk(1'b0, 36'h0,   1'b1, 1'b0, 1'b1, 1'b1, 36'h022, 5'd1, 1'b0, 1'b0);
        vt[11] = mk(1'b0, 36'h0,   1'b1, 1'b0, 1'b1, 1'b0, 36'h0,   5'd0, 1'b0, 1'b0);
        vt[12] = mk(1'b1, 36'h0FF, 1'b0, 1'b1, 1'b1, 1'b0, 36'h0,   5'd0, 1'b0, 1'b0);
        vt[13] = mk(1'b0, 36'h0,   1'b0, 1'b0, 1'b1, 1'b0, 36'h0,   5'd0, 1'b0, 1'b0);

        // Reset state, with a push request held to show port A stays idle.
        RST_N = 1'b0;
        drive(1'b1, 36'h5A5, 1'b1, 1'b0);
        #2;
        chk("rst_wr_ready", 64'(bus.WR_READY), 64'(1));
        chk("rst_rd_valid", 64'(bus.RD_VALID), 64'(0));
        chk("rst_count", 64'(bus.COUNT), 64'(0));
        chk("rst_ena", 64'(bus.BRAM_ENA), 64'(0));
        chk("rst_enb", 64'(bus.BRAM_ENB), 64'(0));
        chk("web_tied", 64'({bus.BRAM_WEB, bus.BRAM_SSRB}), 64'(0));
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Cycle-exact table: single-push latency, two-entry skid fill, flush on empty.
        for (int i = 0; i < int'(NV); i++) begin
            drive(vt[i].wv, vt[i].wd, vt[i].rr, vt[i].fl);
            @(negedge CLK);
            chk($sformatf("v%0d_wr_ready", i), 64'(bus.WR_READY), 64'(vt[i].e_wrdy));
            chk($sformatf("v%0d_rd_valid", i), 64'(bus.RD_VALID), 64'(vt[i].e_rdv));
            if (vt[i].e_rdv)
                chk($sformatf("v%0d_rd_data", i), 64'(bus.RD_DATA), 64'(vt[i].e_rdd));
            chk($sformatf("v%0d_count", i), 64'(bus.COUNT), 64'(vt[i].e_cnt));
            chk($sformatf("v%0d_ena", i), 64'(bus.BRAM_ENA), 64'(vt[i].e_ena));
            chk($sformatf("v%0d_enb", i), 64'(bus.BRAM_ENB), 64'(vt[i].e_enb));
            @(posedge CLK);
            #1;
        end

        // Fill to full, pop while full, then drain in order.
        for (int i = 0; i < 16; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, p);
        chk("full_wr_ready", 64'(bus.WR_READY), 64'(0));
        chk("full_count", 64'(bus.COUNT), 64'(16));
        cyc(1'b1, 36'h99, 1'b0, 1'b0, p);
        cyc(1'b1, 36'h98, 1'b1, 1'b0, p);
        chk("full_pop_ready_next", 64'(bus.WR_READY), 64'(1));
        drain(40);

        // Streaming push+pop every cycle across several pointer wraps.
        first = -1;
        npop  = 0;
        bub   = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, DW'(i + 256), 1'b1, 1'b0, p);
            if (p) begin
                if (first < 0) first = i;
                npop++;
            end else if (first >= 0) begin
                bub++;
            end
        end
        chk("stream_first_pop", 64'(first), 64'(3));
        chk("stream_pops", 64'(npop), 64'(97));
        chk("stream_bubbles", 64'(bub), 64'(0));
        drain(16);

        // Random push and pop backpressure.
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), DW'({$urandom, $urandom}),
                1'($urandom_range(0, 1)), 1'b0, p);
        drain(60);

        // Flush with one entry in the skid and a BRAM read in flight.
        cyc(1'b1, 36'hA0, 1'b0, 1'b0, p);
        cyc(1'b1, 36'hA1, 1'b0, 1'b0, p);
        cyc(1'b1, 36'hA2, 1'b0, 1'b0, p);
        chk("preflush_rd_valid", 64'(bus.RD_VALID), 64'(1));
        cyc(1'b1, 36'hA3, 1'b0, 1'b1, p);
        chk("flush_rd_valid", 64'(bus.RD_VALID), 64'(0));
        chk("flush_count", 64'(bus.COUNT), 64'(0));
        chk("flush_wr_ready", 64'(bus.WR_READY), 64'(1));
        cyc(1'b1, 36'h3C, 1'b1, 1'b0, p);
        drain(16);
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1, 1'b0, p);

        // Asynchronous reset between clock edges during streaming.
        for (int i = 0; i < 6; i++) cyc(1'b1, DW'(i + 36'h700), 1'b1, 1'b0, p);
        chk("pre_rst_rd_valid", 64'(bus.RD_VALID), 64'(1));
        chk("pre_rst_ena", 64'(bus.BRAM_ENA), 64'(1));
        chk("pre_rst_enb", 64'(bus.BRAM_ENB), 64'(1));
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rd_valid", 64'(bus.RD_VALID), 64'(0));
        chk("async_ena", 64'(bus.BRAM_ENA), 64'(0));
        chk("async_enb", 64'(bus.BRAM_ENB), 64'(0));
        chk("async_count", 64'(bus.COUNT), 64'(0));
        chk("async_wr_ready", 64'(bus.WR_READY), 64'(1));
        sb.delete();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        cyc(1'b1, 36'h155, 1'b1, 1'b0, p);
        drain(16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
